// File: rtl/pc_next_unit.sv
// Next-PC generation with redirect priority, a post-redirect squash window and an optional JR alignment trap.
// Define PC_ALIGN_CHECK_EN to trap misaligned JR targets; when undefined, JR targets are forced word-aligned.
module pc_next_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        branch_i,
    input  logic [31:0] offset_sl2_i,
    input  logic        jump_i,
    input  logic [25:0] jump_target_i,
    input  logic        jr_i,
    input  logic [31:0] jr_addr_i,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic        valid_o,
    output logic        flush_o,
    output logic        misalign_o
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        HALT  = 2'd3
    } state_e;

    localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES);

    state_e      state_q;
    logic [31:0] pc_q;
    logic [1:0]  flush_cnt_q;
    logic        misalign_q;

    logic [31:0] pc_plus4;
    logic [31:0] redirect_pc_d;
    logic        redirect;
    logic        jr_misaligned;

    assign pc_plus4 = pc_q + 32'd4;
    assign redirect = jr_i | jump_i | branch_i;

`ifdef PC_ALIGN_CHECK_EN
    assign jr_misaligned = jr_i && (jr_addr_i[1:0] != 2'b00);
`else
    assign jr_misaligned = 1'b0;
`endif

    // Redirect target by priority; masking the JR low bits is a no-op for aligned targets.
    always_comb begin
        redirect_pc_d = pc_plus4;
        if (jr_i) begin
            redirect_pc_d = jr_addr_i & 32'hFFFF_FFFC;
        end else if (jump_i) begin
            redirect_pc_d = {pc_plus4[31:28], jump_target_i, 2'b00};
        end else if (branch_i) begin
            redirect_pc_d = pc_plus4 + offset_sl2_i;
        end
    end

    // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= BOOT;
            pc_q        <= RESET_PC;
            flush_cnt_q <= 2'd0;
            misalign_q  <= 1'b0;
        end else begin
            misalign_q <= 1'b0;
            case (state_q)
                BOOT: begin
                    if (!stall_i) state_q <= RUN;
                end
                RUN: begin
                    if (!stall_i) begin
                        if (jr_misaligned) begin
                            state_q    <= HALT;
                            misalign_q <= 1'b1;
                        end else if (redirect) begin
                            pc_q        <= redirect_pc_d;
                            state_q     <= FLUSH;
                            flush_cnt_q <= FLUSH_LOAD;
                        end else begin
                            pc_q <= pc_plus4;
                        end
                    end
                end
                FLUSH: begin
                    if (!stall_i) begin
                        pc_q        <= pc_plus4;
                        flush_cnt_q <= flush_cnt_q - 2'd1;
                        if (flush_cnt_q == 2'd1) state_q <= RUN;
                    end
                end
                HALT: begin
                    state_q <= HALT;
                end
                default: state_q <= BOOT;
            endcase
        end
    end

    assign pc_o       = pc_q;
    assign pc_plus4_o = pc_plus4;
    assign valid_o    = (state_q == RUN) || (state_q == FLUSH);
    assign flush_o    = (state_q == FLUSH);
    assign misalign_o = misalign_q;

endmodule
